// File: rtl/md5_guess_arbiter.sv
// md5_guess_arbiter: round-robin arbiter that feeds plaintext guesses from
// NUM_REQ requesters into a single MD5 core, one guess in flight at a time,
// and compares each returned digest against target_hash.
// Optional watchdog on the WAIT state: define MD5_ARB_TIMEOUT_EN.
// All outputs are registered; grant and core_start pulse in the cycle after
// the state decision that produces them.

module md5_guess_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [127:0]                 target_hash,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*128-1:0]       guess,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         core_start,
    output logic [127:0]                 core_data,
    input  logic                         core_ready,
    input  logic                         core_valid,
    input  logic [127:0]                 core_hash,
    output logic                         found,
    output logic [$clog2(NUM_REQ)-1:0]   found_id,
    output logic [127:0]                 found_plaintext,
    output logic                         busy,
    output logic [31:0]                  hash_count,
    output logic                         timeout_err
);

    localparam int unsigned DW  = 128;
    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_ptr_d;
    logic [IDW-1:0]     owner;
    logic [IDW-1:0]     owner_d;
    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     idx;
    logic               any_req;
    logic [DW-1:0]      hash_q;
    logic [DW-1:0]      hash_d;
    logic [DW-1:0]      core_data_d;
    logic [DW-1:0]      found_plaintext_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               core_start_d;
    logic               found_d;
    logic [IDW-1:0]     found_id_d;
    logic               busy_d;
    logic [CW-1:0]      hash_count_d;
    logic               match;

`ifdef MD5_ARB_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;
    logic [WDW-1:0] wd_cnt_d;
    logic           wd_expire;
    logic           timeout_err_d;

    // Last WAIT cycle allowed before the guess is abandoned.
    assign wd_expire = (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
`endif

    // Full-width digest compare; target_hash only matters while in COMPARE.
    assign match = (hash_q == target_hash);

    // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        any_req = 1'b0;
        sel     = rr_ptr;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + IDW'(k);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (core_ready) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_valid) begin
                    next_state = S_COMPARE;
                end
`ifdef MD5_ARB_TIMEOUT_EN
                else if (wd_expire) begin
                    next_state = S_IDLE;
                end
`endif
            end
            S_COMPARE: begin
                next_state = match ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                next_state = S_DONE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output / datapath next values; every register holds unless its state acts.
    always_comb begin
        grant_d           = '0;
        core_start_d      = 1'b0;
        core_data_d       = core_data;
        owner_d           = owner;
        rr_ptr_d          = rr_ptr;
        hash_d            = hash_q;
        hash_count_d      = hash_count;
        found_d           = found;
        found_id_d        = found_id;
        found_plaintext_d = found_plaintext;
`ifdef MD5_ARB_TIMEOUT_EN
        wd_cnt_d          = wd_cnt;
        timeout_err_d     = timeout_err;
`endif
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    grant_d     = NUM_REQ'(1) << sel;
                    core_data_d = guess[DW*sel +: DW];
                    owner_d     = sel;
                    rr_ptr_d    = sel + IDW'(1);
                end
            end
            S_ISSUE: begin
                if (core_ready) begin
                    core_start_d = 1'b1;
`ifdef MD5_ARB_TIMEOUT_EN
                    wd_cnt_d     = '0;
`endif
                end
            end
            S_WAIT: begin
                if (core_valid) begin
                    hash_d = core_hash;
                end
`ifdef MD5_ARB_TIMEOUT_EN
                else if (wd_expire) begin
                    timeout_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt + WDW'(1);
                end
`endif
            end
            S_COMPARE: begin
                if (hash_count != '1) begin
                    hash_count_d = hash_count + CW'(1);
                end
                if (match) begin
                    found_d           = 1'b1;
                    found_id_d        = owner;
                    found_plaintext_d = core_data;
                end
            end
            default: begin
            end
        endcase
        busy_d = (next_state == S_ISSUE) || (next_state == S_WAIT) ||
                 (next_state == S_COMPARE);
    end

    // Output and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant           <= '0;
            core_start      <= 1'b0;
            core_data       <= '0;
            owner           <= '0;
            rr_ptr          <= '0;
            hash_q          <= '0;
            hash_count      <= '0;
            found           <= 1'b0;
            found_id        <= '0;
            found_plaintext <= '0;
            busy            <= 1'b0;
        end else begin
            grant           <= grant_d;
            core_start      <= core_start_d;
            core_data       <= core_data_d;
            owner           <= owner_d;
            rr_ptr          <= rr_ptr_d;
            hash_q          <= hash_d;
            hash_count      <= hash_count_d;
            found           <= found_d;
            found_id        <= found_id_d;
            found_plaintext <= found_plaintext_d;
            busy            <= busy_d;
        end
    end

`ifdef MD5_ARB_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt      <= wd_cnt_d;
            timeout_err <= timeout_err_d;
        end
    end
`else
    // Watchdog compiled out: flag is constant low; the expression keeps
    // TIMEOUT_CYCLES referenced so both builds share one parameter list.
    assign timeout_err = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: doc/md5_guess_arbiter.md
MD5_GUESS_ARBITER -- requirements
Module: md5_guess_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of guess requesters (power of two, 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 256: watchdog limit, used only when MD5_ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL use a single clock, clk; reset SHALL be synchronous and active-low on port reset.
REQ-004 Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- target_hash  in  128  digest being searched for
- req  in  NUM_REQ  per-requester guess-ready
- guess  in  NUM_REQ*128  flattened plaintext guesses; requester i occupies bits [128*i+127:128*i]
- grant  out  NUM_REQ  one-hot, one-cycle pulse: guess accepted
- core_start  out  1  one-cycle start pulse to MD5 core
- core_data  out  128  plaintext presented to core
- core_ready  in  1  core idle and able to accept start
- core_valid  in  1  one-cycle pulse: core_hash valid
- core_hash  in  128  digest from core
- found  out  1  sticky match flag
- found_id  out  clog2(NUM_REQ)  requester that produced the match
- found_plaintext  out  128  matching guess
- busy  out  1  a guess is in flight
- hash_count  out  32  completed comparisons, saturating
- timeout_err  out  1  sticky watchdog flag; tied 0 when the feature is compiled out

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT, COMPARE, DONE.
REQ-006 IDLE: if any req bit is set, select one round-robin starting at pointer rr_ptr; pulse grant[sel] for that cycle; latch guess[sel] into core_data and sel into an owner register; go to ISSUE.
REQ-007 rr_ptr SHALL become (sel+1) mod NUM_REQ in the grant cycle; wrap from NUM_REQ-1 to 0.
REQ-008 ISSUE: hold until core_ready=1, then pulse core_start for exactly one cycle and go to WAIT; core_data SHALL stay stable from ISSUE entry until COMPARE exit.
REQ-009 WAIT: on core_valid=1, latch core_hash and go to COMPARE; core_valid in any other state SHALL be ignored.
REQ-010 COMPARE (one cycle): increment hash_count, saturating at 32'hFFFFFFFF; on a 128-bit equality with target_hash, set found, load found_id from the owner register and found_plaintext from core_data, then go to DONE; otherwise go to IDLE.
REQ-011 DONE is terminal until reset: no grant, no core_start, and found stays 1.
REQ-012 busy SHALL be 1 in ISSUE, WAIT and COMPARE, and 0 in IDLE and DONE.
REQ-013 Minimum turnaround SHALL be IDLE->ISSUE->WAIT->COMPARE->IDLE, so at most one guess is in flight.
REQ-014 Requesters that stay asserted SHALL each receive a grant within NUM_REQ hash operations.
REQ-015 target_hash SHALL be sampled only in COMPARE, so changes take effect on the next comparison.

Reset
REQ-016 While reset=0 at a clk edge the block SHALL enter IDLE, set rr_ptr=0, and clear every output and internal register to 0, regardless of state; a result arriving later from an aborted hash SHALL be ignored.

Configuration
REQ-017 When macro MD5_ARB_TIMEOUT_EN is defined: a counter SHALL clear on WAIT entry and increment each WAIT cycle; if it reaches TIMEOUT_CYCLES without core_valid, set timeout_err (sticky), drop the guess without counting it, and return to IDLE.
REQ-018 When MD5_ARB_TIMEOUT_EN is undefined: no counter SHALL exist, WAIT SHALL wait indefinitely, and timeout_err SHALL be constant 0.

Verification
REQ-019 Reset held 3 cycles mid-WAIT -> all outputs 0 and state IDLE the cycle after release; a core_valid pulse arriving afterwards leaves hash_count at 0.
REQ-020 req=4'b1111 held with no match, 8 hashes -> grant order 0,1,2,3,0,1,2,3; hash_count=8.
REQ-021 req=4'b0100, core returns target_hash 2db1850a4fe292bd2706ffd78dbe44b9 for guess "vader" -> found=1, found_id=2, found_plaintext="vader" zero-extended to 128 bits; no further grants.
REQ-022 core_ready held 0 for 10 cycles in ISSUE -> core_start stays 0 and core_data is stable, then a single core_start pulse follows ready going to 1.
REQ-023 With MD5_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_valid withheld -> timeout_err=1 after 16 WAIT cycles, back to IDLE, hash_count unchanged.
REQ-024 hash_count preloaded near saturation via force, 3 further comparisons -> value holds at 32'hFFFFFFFF.
